// File: rtl/buffered_inport.sv
// buffered_inport: valid/ready input port with DEPTH-entry FIFO, status word, sticky flags and threshold irq
module buffered_inport #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 8,
    parameter int DROP_ON_FULL = 0,
    parameter int IRQ_THRESH   = 1
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       sclr,
    input  logic [WIDTH-1:0]           dev_data,
    input  logic                       dev_valid,
    output logic                       dev_ready,
    input  logic                       rd_en,
    input  logic                       stat_sel,
    output logic [WIDTH-1:0]           q,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       irq
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_q;
    logic             r_ovf;
    logic             r_unf;

    logic             w_empty;
    logic             w_full;
    logic             w_rd_data;
    logic             w_rd_stat;
    logic             w_pop;
    logic             w_push;
    logic             w_ovf_evt;
    logic             w_unf_evt;
    logic [WIDTH-1:0] w_status;

    assign w_empty   = r_count == '0;
    assign w_full    = r_count == (AW+1)'(DEPTH);
    assign dev_ready = (DROP_ON_FULL != 0) ? 1'b1 : !w_full;
    assign w_rd_data = rd_en && !stat_sel;
    assign w_rd_stat = rd_en && stat_sel;
    assign w_pop     = w_rd_data && !w_empty;
    assign w_unf_evt = w_rd_data && w_empty;
    // a pop in the same cycle frees the slot, so a full FIFO can still take the word
    assign w_push    = dev_valid && dev_ready && (!w_full || w_pop);
    assign w_ovf_evt = (DROP_ON_FULL != 0) && dev_valid && w_full && !w_pop;

    assign q     = r_q;
    assign empty = w_empty;
    assign full  = w_full;
    assign count = r_count;
    assign irq   = r_count >= (AW+1)'(IRQ_THRESH);

    // status word built from pre-edge occupancy and flags
    always_comb begin
        w_status             = '0;
        w_status[AW:0]       = r_count;
        w_status[AW+1]       = w_empty;
        w_status[AW+2]       = w_full;
        w_status[AW+3]       = r_ovf;
        w_status[AW+4]       = r_unf;
    end

    // storage has no reset; stale entries are never read because pointers are cleared
    always_ff @(posedge clk) begin
        if (w_push && !sclr)
            r_mem[r_wptr] <= dev_data;
    end

    // pointers, occupancy, read register and sticky flags
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_q     <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (sclr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_q     <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (rd_en)
                r_q <= stat_sel ? w_status : (w_pop ? r_mem[r_rptr] : '0);
            r_ovf <= w_ovf_evt || (r_ovf && !w_rd_stat);
            r_unf <= w_unf_evt || (r_unf && !w_rd_stat);
        end
    end
endmodule

// File: tb/tb_buffered_inport.sv
// tb_buffered_inport: checks backpressure and drop-on-full instances against a queue model and a vector table
module tb_buffered_inport;
    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        sclr = 1'b0;
    logic [31:0] dev_data = '0;
    logic        dev_valid = 1'b0;
    logic        rd_en = 1'b0;
    logic        stat_sel = 1'b0;
    logic        rdy_o [2];
    logic [31:0] q_o [2];
    logic        empty_o [2];
    logic        full_o [2];
    logic [2:0]  count_o [2];
    logic        irq_o [2];

    int total = 0;
    int bad = 0;

    logic [31:0] mq [2][$];
    bit          mov [2];
    bit          mun [2];
    logic [31:0] mqo [2];

    typedef struct {
        bit          sc;
        bit          v;
        logic [31:0] d;
        bit          rd;
        bit          sel;
        logic [31:0] eq0;
        int          ec0;
        logic [31:0] eq1;
        int          ec1;
    } vec_t;

    always #5 clk = ~clk;

    buffered_inport #(.WIDTH(32), .DEPTH(4), .DROP_ON_FULL(0), .IRQ_THRESH(2)) u_bp (
        .clk(clk), .clr_n(clr_n), .sclr(sclr), .dev_data(dev_data), .dev_valid(dev_valid),
        .dev_ready(rdy_o[0]), .rd_en(rd_en), .stat_sel(stat_sel), .q(q_o[0]),
        .empty(empty_o[0]), .full(full_o[0]), .count(count_o[0]), .irq(irq_o[0]));

    buffered_inport #(.WIDTH(32), .DEPTH(4), .DROP_ON_FULL(1), .IRQ_THRESH(2)) u_drop (
        .clk(clk), .clr_n(clr_n), .sclr(sclr), .dev_data(dev_data), .dev_valid(dev_valid),
        .dev_ready(rdy_o[1]), .rd_en(rd_en), .stat_sel(stat_sel), .q(q_o[1]),
        .empty(empty_o[1]), .full(full_o[1]), .count(count_o[1]), .irq(irq_o[1]));

    task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] act=%0h exp=%0h at %0t", name, m, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            mov[m] = 0;
            mun[m] = 0;
            mqo[m] = '0;
        end
    endtask

    // one clock of the port's rules, evaluated on pre-edge state
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            int n;
            bit fl, rdy, rdd, pop, unf, push, ovf, srd;
            n    = mq[m].size();
            fl   = n == 4;
            rdy  = (m == 1) || !fl;
            rdd  = rd_en && !stat_sel;
            srd  = rd_en && stat_sel;
            pop  = rdd && n > 0;
            unf  = rdd && n == 0;
            push = dev_valid && rdy && (n - int'(pop) < 4);
            ovf  = (m == 1) && dev_valid && fl && !pop;
            if (sclr) begin
                mq[m].delete();
                mov[m] = 0;
                mun[m] = 0;
                mqo[m] = '0;
            end else begin
                if (rd_en)
                    mqo[m] = stat_sel ? {25'b0, mun[m], mov[m], fl, n == 0, 3'(n)} : (pop ? mq[m][0] : 32'h0);
                mov[m] = ovf || (mov[m] && !srd);
                mun[m] = unf || (mun[m] && !srd);
                if (pop)
                    void'(mq[m].pop_front());
                if (push)
                    mq[m].push_back(dev_data);
            end
        end
    endtask

    task automatic check_model();
        for (int m = 0; m < 2; m++) begin
            int n;
            n = mq[m].size();
            chk("q", m, q_o[m], mqo[m]);
            chk("count", m, 32'(count_o[m]), 32'(n));
            chk("empty", m, 32'(empty_o[m]), 32'(n == 0));
            chk("full", m, 32'(full_o[m]), 32'(n == 4));
            chk("irq", m, 32'(irq_o[m]), 32'(n >= 2));
            chk("ready", m, 32'(rdy_o[m]), 32'((m == 1) || n < 4));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic drive(input bit sc, input bit v, input logic [31:0] d, input bit rd, input bit sel);
        sclr = sc;
        dev_valid = v;
        dev_data = d;
        rd_en = rd;
        stat_sel = sel;
    endtask

    vec_t vt [$];

    initial begin
        vt = '{
            '{0, 1, 32'hA5A5_0001, 0, 0, 32'h0, 1, 32'h0, 1},
            '{0, 1, 32'hA5A5_0002, 0, 0, 32'h0, 2, 32'h0, 2},
            '{1, 1, 32'hDEAD_BEEF, 1, 0, 32'h0, 0, 32'h0, 0},
            '{0, 1, 32'h11, 0, 0, 32'h0, 1, 32'h0, 1},
            '{0, 1, 32'h22, 0, 0, 32'h0, 2, 32'h0, 2},
            '{0, 1, 32'h33, 0, 0, 32'h0, 3, 32'h0, 3},
            '{0, 1, 32'h44, 0, 0, 32'h0, 4, 32'h0, 4},
            '{0, 1, 32'h99, 0, 0, 32'h0, 4, 32'h0, 4},
            '{0, 0, 32'h0, 1, 1, 32'h14, 4, 32'h34, 4},
            '{0, 0, 32'h0, 1, 1, 32'h14, 4, 32'h14, 4},
            '{0, 1, 32'h77, 1, 0, 32'h11, 3, 32'h11, 4},
            '{0, 0, 32'h0, 1, 0, 32'h22, 2, 32'h22, 3},
            '{0, 0, 32'h0, 1, 0, 32'h33, 1, 32'h33, 2},
            '{0, 0, 32'h0, 1, 0, 32'h44, 0, 32'h44, 1},
            '{0, 0, 32'h0, 0, 0, 32'h44, 0, 32'h44, 1},
            '{0, 0, 32'h0, 1, 0, 32'h0, 0, 32'h77, 0},
            '{0, 0, 32'h0, 1, 1, 32'h48, 0, 32'h08, 0},
            '{0, 0, 32'h0, 1, 1, 32'h08, 0, 32'h08, 0},
            '{0, 1, 32'h55, 1, 0, 32'h0, 1, 32'h0, 1},
            '{0, 0, 32'h0, 1, 1, 32'h41, 1, 32'h41, 1},
            '{0, 0, 32'h0, 1, 0, 32'h55, 0, 32'h55, 0},
            '{0, 1, 32'h66, 0, 0, 32'h55, 1, 32'h55, 1},
            '{1, 1, 32'h67, 1, 1, 32'h0, 0, 32'h0, 0}
        };
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("rst_q", m, q_o[m], 32'h0);
            chk("rst_count", m, 32'(count_o[m]), 32'h0);
            chk("rst_empty", m, 32'(empty_o[m]), 32'h1);
            chk("rst_full", m, 32'(full_o[m]), 32'h0);
            chk("rst_irq", m, 32'(irq_o[m]), 32'h0);
            chk("rst_ready", m, 32'(rdy_o[m]), 32'h1);
        end
        clr_n = 1'b1;
        foreach (vt[i]) begin
            drive(vt[i].sc, vt[i].v, vt[i].d, vt[i].rd, vt[i].sel);
            cycle();
            chk($sformatf("vec%0d_q", i), 0, q_o[0], vt[i].eq0);
            chk($sformatf("vec%0d_cnt", i), 0, 32'(count_o[0]), 32'(vt[i].ec0));
            chk($sformatf("vec%0d_irq", i), 0, 32'(irq_o[0]), 32'(vt[i].ec0 >= 2));
            chk($sformatf("vec%0d_q", i), 1, q_o[1], vt[i].eq1);
            chk($sformatf("vec%0d_cnt", i), 1, 32'(count_o[1]), 32'(vt[i].ec1));
            chk($sformatf("vec%0d_irq", i), 1, 32'(irq_o[1]), 32'(vt[i].ec1 >= 2));
        end
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) drive(0, 1, 32'hC000_0000 + 32'(i), 0, 0);
            else            drive(0, 0, 32'h0, 1, 0);
            cycle();
        end
        for (int i = 0; i < 1200; i++) begin
            bit fill;
            fill = ((i / 60) % 2) == 0;
            drive(($urandom % 113) == 0,
                  fill ? ($urandom % 4 != 0) : ($urandom % 4 == 0),
                  $urandom,
                  fill ? ($urandom % 4 == 0) : ($urandom % 4 != 0),
                  ($urandom % 5) == 0);
            cycle();
        end
        drive(0, 1, 32'hBEEF_0001, 0, 0);
        cycle();
        drive(0, 1, 32'hBEEF_0002, 0, 0);
        cycle();
        drive(0, 1, 32'hBEEF_0003, 0, 0);
        #3;
        clr_n = 1'b0;
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            chk("async_count", m, 32'(count_o[m]), 32'h0);
            chk("async_q", m, q_o[m], 32'h0);
            chk("async_empty", m, 32'(empty_o[m]), 32'h1);
        end
        @(posedge clk);
        #1;
        check_model();
        clr_n = 1'b1;
        drive(0, 0, 32'h0, 1, 0);
        cycle();
        drive(0, 0, 32'h0, 1, 1);
        cycle();
        drive(0, 0, 32'h0, 0, 0);
        cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
